// File: rtl/dmc_pkg.sv
// Package for the byte-serial data-memory controller.
// Holds the controller FSM state encoding, the LW/SW opcodes shared with the
// CPU decoder, and the word size in bytes.
package dmc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } dmc_state_e;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_ram.sv
// Byte-wide RAM behind the data-memory controller.
// Ports:
//   clk_i    clock, writes happen on the rising edge
//   rst_i    asynchronous active-high reset, clears every byte to 0
//   we_i     write enable for the single synchronous write port
//   waddr_i  write byte index
//   wdata_i  write byte
//   raddr_i  read byte index (combinational read)
//   rdata_o  read byte
// mem_r is kept as a plain array so it can be inspected hierarchically.
module byte_ram #(
  parameter int MEM_BYTES = 128,
  parameter int AW        = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_r [MEM_BYTES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (we_i) begin
      mem_r[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle byte-serial data-memory controller for the CPU LW/SW path.
// A word access moves one byte per clock through a little-endian byte RAM:
//   word = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, addresses wrap mod MEM_BYTES.
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset; aborts any access in flight
//   req_i    request valid
//   we_i     1 = store word, 0 = load word (sampled at acceptance)
//   addr_i   byte address (sampled at acceptance)
//   wdata_i  store data (sampled at acceptance)
//   ready_o  high only in IDLE
//   done_o   one-cycle completion pulse
//   rdata_o  load result, valid with done_o and held until the next acceptance
//   err_o    range/alignment error flag, valid with done_o
// Handshake: a request is accepted on a rising edge where req_i && ready_o.
//   Requests seen while ready_o is low are ignored, not queued; the requester
//   keeps req_i asserted until it sees ready_o.
// Optional feature (macro DMC_RANGE_CHECK_EN): flag misaligned or out-of-range
//   addresses, skip the byte transfer and raise err_o with done_o. Without the
//   macro, addresses simply wrap and err_o is tied to 0.
// The FSM state is visible as state_q for debug.
module data_mem_ctrl
  import dmc_pkg::*;
#(
  parameter int MEM_BYTES = 128,
  parameter int AW        = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  dmc_state_e    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic          we_lat_q, we_lat_d;
  logic [AW-1:0] addr_lat_q, addr_lat_d;
  logic [31:0]   wdata_lat_q, wdata_lat_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;

  logic          accept;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rdata;

  assign accept = req_i && ready_q;

  // Byte address for the current lane; the AW-bit add wraps past the top.
  assign ram_addr = addr_lat_q + {{(AW-2){1'b0}}, idx_q};
  assign ram_we   = (state_q == XFER) && we_lat_q;

  byte_ram #(
    .MEM_BYTES(MEM_BYTES),
    .AW       (AW)
  ) u_ram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (ram_we),
    .waddr_i(ram_addr),
    .wdata_i(wdata_lat_q[8*idx_q +: 8]),
    .raddr_i(ram_addr),
    .rdata_o(ram_rdata)
  );

`ifdef DMC_RANGE_CHECK_EN
  logic err_q, err_d;
  logic range_err;
  assign range_err = (addr_i[1:0] != 2'b00) || (addr_i >= 32'(MEM_BYTES));
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    we_lat_d    = we_lat_q;
    addr_lat_d  = addr_lat_q;
    wdata_lat_d = wdata_lat_q;
    rdata_d     = rdata_q;
    ready_d     = ready_q;
    done_d      = done_q;
`ifdef DMC_RANGE_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_lat_d    = we_i;
          addr_lat_d  = addr_i[AW-1:0];
          wdata_lat_d = wdata_i;
          idx_d       = 2'd0;
          rdata_d     = 32'h0;
          ready_d     = 1'b0;
          state_d     = XFER;
`ifdef DMC_RANGE_CHECK_EN
          // A bad address goes straight to DONE: no RAM traffic at all.
          if (range_err) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
`endif
        end
      end
      XFER: begin
        if (!we_lat_q) begin
          rdata_d[8*idx_q +: 8] = ram_rdata;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
`ifdef DMC_RANGE_CHECK_EN
        err_d   = 1'b0;
`endif
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      we_lat_q    <= 1'b0;
      addr_lat_q  <= '0;
      wdata_lat_q <= 32'h0;
      rdata_q     <= 32'h0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
`ifdef DMC_RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      we_lat_q    <= we_lat_d;
      addr_lat_q  <= addr_lat_d;
      wdata_lat_q <= wdata_lat_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
`ifdef DMC_RANGE_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
`ifdef DMC_RANGE_CHECK_EN
  assign err_o   = err_q;
`else
  assign err_o   = 1'b0;
`endif

endmodule
